// File: rtl/merge_run_sequencer_if.sv
// FIFO-side bundle of the merge sequencer: two FWFT input heads with pop strobes
// and the output FIFO write port with its ready flag.
interface merge_run_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] i_a_data;
    logic              i_a_empty;
    logic              o_a_read;
    logic [DATA_W-1:0] i_b_data;
    logic              i_b_empty;
    logic              o_b_read;
    logic              i_out_ready;
    logic              o_out_write;
    logic [DATA_W-1:0] o_out_data;

    modport master (
        input  i_a_data, i_a_empty, i_b_data, i_b_empty, i_out_ready,
        output o_a_read, o_b_read, o_out_write, o_out_data
    );

    modport slave (
        output i_a_data, i_a_empty, i_b_data, i_b_empty, i_out_ready,
        input  o_a_read, o_b_read, o_out_write, o_out_data
    );
endinterface

// File: rtl/merge_run_sequencer.sv
// Sequences one 2-way merge pass over zero-terminated sorted runs, popping the
// smaller head each cycle and stopping after a programmed number of run pairs.
module merge_run_sequencer #(
    parameter int DATA_W = 32,
    parameter int RUN_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [RUN_W-1:0]     i_num_runs,
    merge_run_sequencer_if.master bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [RUN_W-1:0]     o_runs_done,
    output logic [31:0]          o_elem_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  num_runs_q, num_runs_d;
    logic [RUN_W-1:0]  runs_done_q, runs_done_d;
    logic [31:0]       elem_count_q, elem_count_d;
    logic              out_write_q, out_write_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              a_read;
    logic              b_read;
    logic              a_end;
    logic              b_end;
    logic              fire;
    logic [RUN_W-1:0]  runs_inc;

    // Sentinel 0 ranks above every key; equal keys favour A.
    function automatic logic take_a(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
        if (a == '0) begin
            return 1'b0;
        end
        if (b == '0) begin
            return 1'b1;
        end
        return (a <= b);
    endfunction

    assign a_end    = (bus.i_a_data == '0);
    assign b_end    = (bus.i_b_data == '0);
    assign runs_inc = runs_done_q + 1'b1;
    assign fire     = (state_q == S_MERGE) && !bus.i_a_empty && !bus.i_b_empty
                      && bus.i_out_ready && !i_rst;

    always_comb begin
        state_d      = state_q;
        num_runs_d   = num_runs_q;
        runs_done_d  = runs_done_q;
        elem_count_d = elem_count_q;
        out_write_d  = 1'b0;
        out_data_d   = out_data_q;
        a_read       = 1'b0;
        b_read       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    num_runs_d   = i_num_runs;
                    runs_done_d  = '0;
                    elem_count_d = '0;
                    state_d      = (i_num_runs == '0) ? S_DONE : S_MERGE;
                end
            end
            S_MERGE: begin
                if (fire) begin
                    out_write_d = 1'b1;
                    if (a_end && b_end) begin
                        a_read      = 1'b1;
                        b_read      = 1'b1;
                        out_data_d  = '0;
                        runs_done_d = runs_inc;
                        if (runs_inc == num_runs_q) begin
                            state_d = S_DONE;
                        end
                    end else if (take_a(bus.i_a_data, bus.i_b_data)) begin
                        a_read       = 1'b1;
                        out_data_d   = bus.i_a_data;
                        elem_count_d = elem_count_q + 32'd1;
                    end else begin
                        b_read       = 1'b1;
                        out_data_d   = bus.i_b_data;
                        elem_count_d = elem_count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_MERGE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            num_runs_q   <= '0;
            runs_done_q  <= '0;
            elem_count_q <= '0;
            out_write_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_runs_q   <= num_runs_d;
            runs_done_q  <= runs_done_d;
            elem_count_q <= elem_count_d;
            out_write_q  <= out_write_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_a_read    = a_read;
    assign bus.o_b_read    = b_read;
    assign bus.o_out_write = out_write_q;
    assign bus.o_out_data  = out_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_runs_done     = runs_done_q;
    assign o_elem_count    = elem_count_q;

endmodule

// File: tb/tb_merge_run_sequencer.sv
// Randomised scoreboard bench for merge_run_sequencer: FIFO models drive the heads,
// a sort-based reference predicts each merged run, a monitor checks every write.
module tb_merge_run_sequencer;
    localparam int DATA_W = 32;
    localparam int RUN_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [RUN_W-1:0] num_runs = '0;
    logic             busy, done;
    logic [RUN_W-1:0] runs_done;
    logic [31:0]      elem_count;

    merge_run_sequencer_if #(.DATA_W(DATA_W)) bus();

    merge_run_sequencer #(.DATA_W(DATA_W), .RUN_W(RUN_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_runs   (num_runs),
        .bus          (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_runs_done  (runs_done),
        .o_elem_count (elem_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int first_wr = 0;
    int last_wr = 0;
    int exp_elems = 0;
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_data = '0;
    bit rand_en = 0;
    bit stall_f = 0;
    bit bempty_f = 0;
    bit s_ra = 0;
    bit s_rb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO A/B models and pop checker
    initial begin
        logic [DATA_W-1:0] ha, hb;
        logic [1:0] exp_sel;
        bit fire_ok;
        bus.i_a_data = '0;
        bus.i_a_empty = 1'b1;
        bus.i_b_data = '0;
        bus.i_b_empty = 1'b1;
        bus.i_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ra && qa.size() > 0) void'(qa.pop_front());
            if (s_rb && qb.size() > 0) void'(qb.pop_front());
            s_ra = 0;
            s_rb = 0;
            bus.i_a_empty = (qa.size() == 0) || (rand_en && $urandom_range(3) == 0);
            bus.i_a_data  = bus.i_a_empty ? DATA_W'($urandom) : qa[0];
            bus.i_b_empty = (qb.size() == 0) || bempty_f || (rand_en && $urandom_range(3) == 0);
            bus.i_b_data  = bus.i_b_empty ? DATA_W'($urandom) : qb[0];
            bus.i_out_ready = !stall_f && !(rand_en && $urandom_range(3) == 0);
            #4;
            s_ra = bus.o_a_read;
            s_rb = bus.o_b_read;
            fire_ok = !rst && busy && !bus.i_a_empty && !bus.i_b_empty && bus.i_out_ready;
            if (rst) begin
                check("pop_in_reset", {s_ra, s_rb}, 2'b00);
            end else if (fire_ok) begin
                ha = qa[0];
                hb = qb[0];
                if (ha == 0 && hb == 0)      exp_sel = 2'b11;
                else if (ha == 0)            exp_sel = 2'b01;
                else if (hb == 0)            exp_sel = 2'b10;
                else if (ha <= hb)           exp_sel = 2'b10;
                else                         exp_sel = 2'b01;
                check("pop_select", {s_ra, s_rb}, exp_sel);
            end else if (s_ra || s_rb) begin
                check("pop_without_fire", {s_ra, s_rb}, 2'b00);
            end
        end
    end

    // Output monitor / scoreboard
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data = '0;
            end else if (bus.o_out_write) begin
                check("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.o_out_data, e);
                end
                wr_cnt++;
                if (wr_cnt == 1) first_wr = cyc;
                last_wr = cyc;
                last_data = bus.o_out_data;
            end else begin
                check("data_hold", bus.o_out_data, last_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation timeout");
    end

    // Reference: each pass output is the sorted union of the paired runs, then 0.
    task automatic build_expect(input int n);
        logic [DATA_W-1:0] ta[$];
        logic [DATA_W-1:0] tb[$];
        logic [DATA_W-1:0] tmp[$];
        logic [DATA_W-1:0] v;
        ta = qa;
        tb = qb;
        exp_elems = 0;
        for (int p = 0; p < n; p++) begin
            tmp.delete();
            while (ta.size() > 0) begin
                v = ta.pop_front();
                if (v == 0) break;
                tmp.push_back(v);
            end
            while (tb.size() > 0) begin
                v = tb.pop_front();
                if (v == 0) break;
                tmp.push_back(v);
            end
            tmp.sort();
            foreach (tmp[i]) begin
                exp_q.push_back(tmp[i]);
                exp_elems++;
            end
            exp_q.push_back('0);
        end
    endtask

    task automatic gen_run(input bit to_a);
        logic [DATA_W-1:0] tmp[$];
        logic [DATA_W-1:0] v;
        int len;
        len = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(2))
                0:       v = DATA_W'($urandom_range(1, 8));
                1:       v = DATA_W'($urandom_range(1, 1000));
                default: v = DATA_W'($urandom) | 32'h8000_0000;
            endcase
            tmp.push_back(v);
        end
        tmp.sort();
        tmp.push_back('0);
        foreach (tmp[i]) begin
            if (to_a) qa.push_back(tmp[i]);
            else      qb.push_back(tmp[i]);
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        #1;
        start = 1'b1;
        num_runs = RUN_W'(n);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        check("done_reached", done, 1'b1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_out_write", bus.o_out_write, 1'b0);
        check("rst_out_data", bus.o_out_data, '0);
        check("rst_runs_done", runs_done, '0);
        check("rst_elem_count", elem_count, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
    endtask

    task automatic post_checks(input int n);
        check("runs_done", runs_done, 64'(n));
        check("elem_count", elem_count, 64'(exp_elems));
        check("busy_after", busy, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_pass(input int n);
        build_expect(n);
        wr_cnt = 0;
        pulse_start(n);
        wait_done(3000);
        post_checks(n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_reset_vals();
        rst = 1'b0;

        // basic merge, back-to-back writes
        qa = '{32'd1, 32'd4, 32'd7, 32'd0};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0};
        run_pass(1);
        check("basic_writes", 64'(wr_cnt), 64'd7);
        check("basic_consecutive", 64'(last_wr - first_wr), 64'd6);

        // ties and uneven runs
        qa = '{32'd5, 32'd5, 32'd0, 32'd8, 32'd0};
        qb = '{32'd5, 32'd0, 32'd0};
        run_pass(2);

        // backpressure and B empty
        qa = '{32'd1, 32'd4, 32'd7, 32'd0};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0};
        build_expect(1);
        wr_cnt = 0;
        pulse_start(1);
        stall_f = 1;
        repeat (3) @(negedge clk);
        #1;
        stall_f = 0;
        bempty_f = 1;
        repeat (2) @(negedge clk);
        #1;
        bempty_f = 0;
        wait_done(200);
        post_checks(1);
        check("bp_writes", 64'(wr_cnt), 64'd7);

        // zero-run program
        qa = '{32'd1, 32'd0};
        qb = '{32'd2, 32'd0};
        exp_elems = 0;
        pulse_start(0);
        check("zero_done", done, 1'b1);
        check("zero_elems", elem_count, '0);
        check("zero_runs", runs_done, '0);
        repeat (3) @(negedge clk);
        #1;
        check("zero_no_pop_a", 64'(qa.size()), 64'd2);
        check("zero_no_pop_b", 64'(qb.size()), 64'd2);
        qa.delete();
        qb.delete();

        // reset mid-pass
        qa = '{32'd1, 32'd4, 32'd7, 32'd0};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0};
        build_expect(1);
        wr_cnt = 0;
        pulse_start(1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= 3) break;
        end
        check("third_write_seen", 64'(wr_cnt), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_reset_vals();
        exp_q.delete();
        qa.delete();
        qb.delete();
        rst = 1'b0;
        qa = '{32'd1, 32'd4, 32'd7, 32'd0};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0};
        run_pass(1);

        // start ignored while busy
        qa = '{32'd1, 32'd4, 32'd7, 32'd0, 32'd3, 32'd0};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0, 32'd6, 32'd0};
        build_expect(1);
        wr_cnt = 0;
        pulse_start(1);
        start = 1'b1;
        num_runs = RUN_W'(5);
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        post_checks(1);
        repeat (4) @(negedge clk);
        #1;
        check("ignored_left_a", 64'(qa.size()), 64'd2);
        check("ignored_left_b", 64'(qb.size()), 64'd2);
        qa.delete();
        qb.delete();

        // randomised passes with random stalls and empties
        rand_en = 1;
        for (int t = 0; t < 12; t++) begin
            int n, pairs;
            n = $urandom_range(1, 4);
            pairs = n + $urandom_range(1);
            for (int p = 0; p < pairs; p++) begin
                gen_run(1'b1);
                gen_run(1'b0);
            end
            run_pass(n);
            qa.delete();
            qb.delete();
        end
        rand_en = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/merge_run_sequencer.md
Name: merge_run_sequencer

Overview:
- Controller that sequences one 2-way streaming merge pass over zero-terminated sorted runs.
- Two first-word-fall-through input FIFOs (A, B) each hold a sequence of ascending runs of nonzero keys; each run ends with a 0 sentinel.
- The block pops the smaller head each cycle and writes it to the output FIFO, with 0 treated as +infinity. It emits one merged run plus one 0 sentinel per A/B run pair.
- It counts completed run pairs and stops after a programmed number, so a merge-tree level can be started, monitored and restarted by the host sequencer.

Parameters:
DATA_W  32  key width; key value 0 is reserved as the end-of-run sentinel
RUN_W  16  width of the run-pair count and run counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous active-high reset
i_start  input  1  start pulse; honoured only in IDLE or DONE
i_num_runs  input  RUN_W  number of run pairs to merge; latched when i_start is accepted
i_a_data  input  DATA_W  head of FIFO A; valid when i_a_empty=0
i_a_empty  input  1  FIFO A empty
i_b_data  input  DATA_W  head of FIFO B; valid when i_b_empty=0
i_b_empty  input  1  FIFO B empty
i_out_ready  input  1  output FIFO can accept a word this cycle
o_a_read  output  1  pop FIFO A this cycle (combinational)
o_b_read  output  1  pop FIFO B this cycle (combinational)
o_out_write  output  1  registered write strobe to output FIFO
o_out_data  output  DATA_W  registered output word
o_busy  output  1  state is MERGE
o_done  output  1  state is DONE
o_runs_done  output  RUN_W  run pairs completed in the current pass
o_elem_count  output  32  nonzero keys emitted in the current pass; wraps mod 2^32

Behaviour:
- States: IDLE, MERGE, DONE. All state and outputs are registered except o_a_read and o_b_read.
- Reset: state=IDLE. o_out_write=0, o_out_data=0, o_runs_done=0, o_elem_count=0, o_busy=0, o_done=0. o_a_read and o_b_read are forced to 0 while i_rst=1.
- Reset mid-operation: a reset in MERGE aborts the pass with no pop in that cycle. A word already registered is dropped, because o_out_write clears on the next edge.
- IDLE/DONE + i_start:
  - Latch i_num_runs; clear o_runs_done and o_elem_count.
  - If i_num_runs=0, go to DONE; otherwise go to MERGE.
  - i_start in MERGE is ignored.
- Fire condition in MERGE: fire = ~i_a_empty & ~i_b_empty & i_out_ready. Both heads are always required, even if one of them is a sentinel.
- When fire=1, with a=i_a_data and b=i_b_data:
  - a!=0, b!=0, a<=b: o_a_read=1; emit a (a tie selects A).
  - a!=0, b!=0, a>b: o_b_read=1; emit b.
  - a=0, b!=0: o_b_read=1; emit b.
  - a!=0, b=0: o_a_read=1; emit a.
  - a=0, b=0: o_a_read=1 and o_b_read=1; emit 0; o_runs_done increments.
    - If the incremented value equals the latched count, go to DONE; otherwise stay in MERGE.
- Emit: on the edge after fire, o_out_write=1 and o_out_data=emitted word. If the word is nonzero, o_elem_count increments on that same edge.
- When fire=0: no pops; o_out_write=0 on the next edge; o_out_data holds its value.
- Latency: pop to output-write is exactly 1 cycle. Throughput is 1 word per cycle when fire=1 continuously.
- Backpressure: i_out_ready=0 stalls with no pop. The output FIFO must reserve one slot for the in-flight word, i.e. ready = ~almost_full.
- Comparison is unsigned on DATA_W bits.
- DONE: o_done=1; no pops; stays in DONE until i_start or reset.

Test Plan:
- Basic merge: num_runs=1, A={1,4,7,0}, B={2,3,9,0}, out always ready -> output 1,2,3,4,7,9,0 on 7 consecutive cycles, first write 1 cycle after i_start accepted+1; o_runs_done=1, o_elem_count=6, o_done=1.
- Ties and uneven runs: num_runs=2, A={5,5,0,8,0}, B={5,0,0} -> output 5(A),5(A),5(B),0,8,0; o_elem_count=4, o_runs_done=2.
- Backpressure and empty: same data as the basic-merge test; drop i_out_ready for cycles 2-4 and hold i_b_empty=1 for 2 cycles -> no o_a_read/o_b_read while stalled; output sequence identical to the basic-merge test; o_out_write=0 in stall gaps.
- Zero-run program: i_start with i_num_runs=0 -> DONE next cycle, no pops, o_elem_count=0.
- Reset mid-pass: assert i_rst after the 3rd emitted word -> same-cycle pops=0; next cycle all outputs at reset values, state IDLE; a new i_start restarts counts at 0.
- Start ignored while busy: pulse i_start with num_runs=5 in MERGE -> latched count unchanged; pass ends after the original count.
